mips_fetch_sequencer: RTL and testbench

Instruction fetch and issue sequencer that sits in front of the single-cycle `mipscpu` datapath. It supplies the `mipscpu` inputs `instrword` and `newinstr`, and it owns the PC and the instruction memory, which the CPU core lacks. It steps through a preloaded program, presenting one instruction at a time for a fixed execute window, and handles `j` and a halt opcode. The bench programs the memory through a load port and then pulses `start`.

---
 rtl/mips_pkg.sv | 27 ++
 rtl/mips_imem.sv | 27 ++
 rtl/mips_fetch_sequencer.sv | 143 ++++++++++++++
 tb/tb_mips_fetch_sequencer.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared opcode constants, fetch-state encoding and instruction field helpers
// for the mips fetch/issue front end.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_J     = 6'd2;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SW    = 6'd43;
    localparam logic [5:0] OP_HALT  = 6'd63;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_ISSUE,
        ST_EXEC,
        ST_HALT
    } fetch_state_e;

    function automatic logic [5:0] opcode_of(input logic [31:0] word);
        return word[31:26];
    endfunction

    function automatic logic [25:0] jtarget_of(input logic [31:0] word);
        return word[25:0];
    endfunction

endpackage

// File: rtl/mips_imem.sv
// Instruction memory: synchronous write port for program load, asynchronous
// read port for the fetch stage. Contents survive reset.
module mips_imem
    import mips_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clock,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/mips_fetch_sequencer.sv
// Fetch/issue sequencer feeding the single-cycle mipscpu: owns PC and imem,
// presents one instruction per execute window, handles j and halt.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | after reset; imem loadable, waits for start
// ST_FETCH | read imem[pc_idx]; halt word diverts to ST_HALT
// ST_ISSUE | newinstr high for exactly this cycle
// ST_EXEC  | instrword held for EXEC_CYCLES; last cycle picks next pc_idx
// ST_HALT  | program ended; imem loadable, start re-runs from word 0
module mips_fetch_sequencer
    import mips_pkg::*;
#(
    parameter int          IMEM_DEPTH  = 64,
    parameter int          EXEC_CYCLES = 4,
    parameter logic [5:0]  HALT_OPCODE = OP_HALT,
    parameter int          AW          = $clog2(IMEM_DEPTH)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          prog_we,
    input  logic [AW-1:0] prog_addr,
    input  logic [31:0]   prog_data,
    input  logic          start,
    output logic [31:0]   instrword,
    output logic          newinstr,
    output logic [31:0]   pc,
    output logic          busy,
    output logic          halted,
    output logic [15:0]   instr_count
);

    localparam logic [15:0]   EXEC_LAST = 16'(EXEC_CYCLES - 1);
    localparam logic [AW-1:0] LAST_IDX  = AW'(IMEM_DEPTH - 1);

    fetch_state_e  state_q, state_d;
    logic [AW-1:0] pc_idx_q, pc_idx_d;
    logic [31:0]   instrword_q, instrword_d;
    logic          newinstr_q, newinstr_d;
    logic          busy_q, busy_d;
    logic          halted_q, halted_d;
    logic [15:0]   count_q, count_d;
    logic [15:0]   exec_q, exec_d;
    logic          imem_we;
    logic [31:0]   imem_rdata;

    mips_imem #(
        .DEPTH (IMEM_DEPTH),
        .AW    (AW)
    ) u_imem (
        .clock (clock),
        .we    (imem_we),
        .waddr (prog_addr),
        .wdata (prog_data),
        .raddr (pc_idx_q),
        .rdata (imem_rdata)
    );

    always_comb begin
        state_d     = state_q;
        pc_idx_d    = pc_idx_q;
        instrword_d = instrword_q;
        newinstr_d  = 1'b0;
        count_d     = count_q;
        exec_d      = exec_q;
        imem_we     = 1'b0;

        case (state_q)
            ST_IDLE, ST_HALT: begin
                // The write lands on the same edge as start, so FETCH sees it.
                imem_we = prog_we;
                if (start) begin
                    pc_idx_d = '0;
                    count_d  = '0;
                    state_d  = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (opcode_of(imem_rdata) == HALT_OPCODE) begin
                    state_d = ST_HALT;
                end else begin
                    instrword_d = imem_rdata;
                    newinstr_d  = 1'b1;
                    count_d     = count_q + 16'd1;
                    state_d     = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                exec_d  = EXEC_LAST;
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                if (exec_q == '0) begin
                    if (opcode_of(instrword_q) == OP_J) begin
                        pc_idx_d = instrword_q[AW-1:0];
                        state_d  = ST_FETCH;
                    end else if (pc_idx_q == LAST_IDX) begin
                        state_d = ST_HALT;
                    end else begin
                        pc_idx_d = pc_idx_q + 1'b1;
                        state_d  = ST_FETCH;
                    end
                end else begin
                    exec_d = exec_q - 16'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d   = (state_d == ST_FETCH) || (state_d == ST_ISSUE) || (state_d == ST_EXEC);
        halted_d = (state_d == ST_HALT);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            pc_idx_q    <= '0;
            instrword_q <= '0;
            newinstr_q  <= 1'b0;
            busy_q      <= 1'b0;
            halted_q    <= 1'b0;
            count_q     <= '0;
            exec_q      <= '0;
        end else begin
            state_q     <= state_d;
            pc_idx_q    <= pc_idx_d;
            instrword_q <= instrword_d;
            newinstr_q  <= newinstr_d;
            busy_q      <= busy_d;
            halted_q    <= halted_d;
            count_q     <= count_d;
            exec_q      <= exec_d;
        end
    end

    assign instrword   = instrword_q;
    assign newinstr    = newinstr_q;
    assign pc          = {{(30 - AW){1'b0}}, pc_idx_q, 2'b00};
    assign busy        = busy_q;
    assign halted      = halted_q;
    assign instr_count = count_q;

endmodule

// File: tb/tb_mips_fetch_sequencer.sv
// Scoreboard bench for mips_fetch_sequencer: expected issues are queued by the
// stimulus and checked by a monitor whenever newinstr is seen.
module tb_mips_fetch_sequencer;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        prog_we = 1'b0;
    logic [5:0]  prog_addr = '0;
    logic [31:0] prog_data = '0;
    logic        start = 1'b0;
    logic [31:0] instrword;
    logic        newinstr;
    logic [31:0] pc;
    logic        busy;
    logic        halted;
    logic [15:0] instr_count;

    mips_fetch_sequencer dut (
        .clock       (clock),
        .reset       (reset),
        .prog_we     (prog_we),
        .prog_addr   (prog_addr),
        .prog_data   (prog_data),
        .start       (start),
        .instrword   (instrword),
        .newinstr    (newinstr),
        .pc          (pc),
        .busy        (busy),
        .halted      (halted),
        .instr_count (instr_count)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] word;
        logic [31:0] pc;
        logic [15:0] cnt;
        int          cyc;
    } issue_t;

    issue_t exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int start_cyc = 0;
    logic prev_ni = 1'b0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every newinstr pulse must match the head of the scoreboard.
    always @(negedge clock) begin
        if (newinstr === 1'b1) begin
            issue_t e;
            chk("newinstr_gap", {31'b0, prev_ni}, 32'd0);
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_issue: pc 0x%08h word 0x%08h with empty scoreboard", pc, instrword);
            end else begin
                e = exp_q.pop_front();
                chk("issue_word", instrword, e.word);
                chk("issue_pc", pc, e.pc);
                chk("issue_count", {16'b0, instr_count}, {16'b0, e.cnt});
                chk("issue_cycle", 32'(cyc - start_cyc + 1), 32'(e.cyc));
            end
        end
        prev_ni = newinstr;
    end

    task automatic push(input logic [31:0] word, input int idx, input int n);
        issue_t e;
        e.word = word;
        e.pc   = 32'(idx * 4);
        e.cnt  = 16'(n + 1);
        e.cyc  = 2 + 6 * n;
        exp_q.push_back(e);
    endtask

    task automatic load(input int addr, input logic [31:0] data);
        @(negedge clock);
        prog_we   = 1'b1;
        prog_addr = 6'(addr);
        prog_data = data;
        @(negedge clock);
        prog_we   = 1'b0;
    endtask

    task automatic do_start(input logic we, input int addr, input logic [31:0] data);
        @(negedge clock);
        start     = 1'b1;
        prog_we   = we;
        prog_addr = 6'(addr);
        prog_data = data;
        @(posedge clock);
        #1 start_cyc = cyc;
        @(negedge clock);
        start   = 1'b0;
        prog_we = 1'b0;
    endtask

    task automatic wait_rel(input int k);
        for (int i = 0; i < 1000 && (cyc - start_cyc + 1) < k; i++) @(negedge clock);
    endtask

    task automatic wait_halt(input int max, input string name, output int rel);
        rel = -1;
        for (int i = 0; i < max; i++) begin
            @(negedge clock);
            if (halted === 1'b1) begin
                rel = cyc - start_cyc + 1;
                break;
            end
        end
        if (rel < 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: halted not seen within %0d cycles", name, max);
        end
    endtask

    task automatic load_straight();
        load(0, 32'h00221820);
        load(1, 32'h8C040004);
        load(2, 32'hAC050008);
        load(3, 32'hFC000000);
    endtask

    task automatic push_straight();
        push(32'h00221820, 0, 0);
        push(32'h8C040004, 1, 1);
        push(32'hAC050008, 2, 2);
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_instrword"}, instrword, 32'd0);
        chk({tag, "_newinstr"}, {31'b0, newinstr}, 32'd0);
        chk({tag, "_pc"}, pc, 32'd0);
        chk({tag, "_busy"}, {31'b0, busy}, 32'd0);
        chk({tag, "_halted"}, {31'b0, halted}, 32'd0);
        chk({tag, "_count"}, {16'b0, instr_count}, 32'd0);
    endtask

    initial begin
        int rel;

        // Reset
        repeat (2) @(negedge clock);
        check_idle_outputs("reset");
        reset = 1'b0;
        load_straight();
        @(negedge clock);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        check_idle_outputs("reset2");

        // Straight-line program, imem survived reset
        push_straight();
        do_start(1'b0, 0, 32'h0);
        wait_halt(60, "straight_halt", rel);
        chk("straight_halt_cycle", 32'(rel), 32'd20);
        chk("straight_count", {16'b0, instr_count}, 32'd3);
        chk("straight_pc", pc, 32'd12);
        chk("straight_hold_word", instrword, 32'hAC050008);
        chk("straight_busy", {31'b0, busy}, 32'd0);
        chk("straight_queue", 32'(exp_q.size()), 32'd0);

        // Jump; imem[0] rewritten in the same cycle as start
        load(1, 32'h08000005);
        load(5, 32'hFC000000);
        push(32'h8C040004, 0, 0);
        push(32'h08000005, 1, 1);
        do_start(1'b1, 0, 32'h8C040004);
        wait_halt(60, "jump_halt", rel);
        chk("jump_halt_cycle", 32'(rel), 32'd14);
        chk("jump_pc", pc, 32'd20);
        chk("jump_count", {16'b0, instr_count}, 32'd2);
        chk("jump_queue", 32'(exp_q.size()), 32'd0);

        // Reset mid-EXEC of the second instruction
        load_straight();
        push(32'h00221820, 0, 0);
        push(32'h8C040004, 1, 1);
        do_start(1'b0, 0, 32'h0);
        wait_rel(9);
        reset = 1'b1;
        @(negedge clock);
        chk("midrst_newinstr", {31'b0, newinstr}, 32'd0);
        chk("midrst_busy", {31'b0, busy}, 32'd0);
        chk("midrst_pc", pc, 32'd0);
        chk("midrst_count", {16'b0, instr_count}, 32'd0);
        reset = 1'b0;
        chk("midrst_queue", 32'(exp_q.size()), 32'd0);
        push_straight();
        do_start(1'b0, 0, 32'h0);
        wait_halt(60, "restart_halt", rel);
        chk("restart_halt_cycle", 32'(rel), 32'd20);
        chk("restart_count", {16'b0, instr_count}, 32'd3);

        // prog_we and start ignored while busy
        push_straight();
        do_start(1'b0, 0, 32'h0);
        wait_rel(3);
        prog_we   = 1'b1;
        prog_addr = 6'd2;
        prog_data = 32'h12345678;
        @(negedge clock);
        prog_we = 1'b0;
        wait_rel(9);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        wait_halt(60, "busy_halt", rel);
        chk("busy_halt_cycle", 32'(rel), 32'd20);
        chk("busy_count", {16'b0, instr_count}, 32'd3);
        chk("busy_queue", 32'(exp_q.size()), 32'd0);

        // End of memory: no wrap
        for (int i = 0; i < 64; i++) load(i, 32'h00000020);
        for (int i = 0; i < 64; i++) push(32'h00000020, i, i);
        do_start(1'b0, 0, 32'h0);
        wait_halt(500, "eom_halt", rel);
        chk("eom_halt_cycle", 32'(rel), 32'd385);
        chk("eom_pc", pc, 32'h000000FC);
        chk("eom_count", {16'b0, instr_count}, 32'd64);
        repeat (10) @(negedge clock);
        chk("eom_pc_stays", pc, 32'h000000FC);
        chk("eom_halted_stays", {31'b0, halted}, 32'd1);
        chk("eom_queue", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
